// File: rtl/seq_detect_controller.sv
// seq_detect_controller: programmable overlapping serial-pattern detector
// with a config handshake, armed start, match counting up to a target and abort.
module seq_detect_controller #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               a,
  input  logic               a_valid,
  output logic               busy,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  state_t state, state_n;
  logic [MAX_LEN-1:0] hist, hist_n, pat, pat_n, h_new, mask;
  logic [LW-1:0] fill, fill_n, len, len_n, f_new;
  logic [CNT_W-1:0] tgt, tgt_n, cnt_n, cnt_inc;
  logic det_n, err_n, cfg_ok, hit;
  assign cfg_ready = state == IDLE || state == DONE;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign cfg_ok = cfg_len >= LW'(2) && cfg_len <= LW'(MAX_LEN) && cfg_target != '0;
  assign h_new = {hist[MAX_LEN-2:0], a};
  assign f_new = fill == len ? fill : fill + LW'(1);
  // only the low len bits of history and pattern take part in a match
  assign mask = ~({MAX_LEN{1'b1}} << len);
  assign hit = ((h_new ^ pat) & mask) == '0 && f_new == len;
  assign cnt_inc = match_count + CNT_W'(1);
  always_comb begin
    state_n = state;
    hist_n = hist;
    fill_n = fill;
    cnt_n = match_count;
    pat_n = pat;
    len_n = len;
    tgt_n = tgt;
    det_n = 1'b0;
    err_n = 1'b0;
    if (abort) begin
      state_n = IDLE;
      hist_n = '0;
      fill_n = '0;
      cnt_n = '0;
    end else if (cfg_ready && cfg_valid) begin
      state_n = cfg_ok ? ARMED : state;
      pat_n = cfg_ok ? cfg_pattern : pat;
      len_n = cfg_ok ? cfg_len : len;
      tgt_n = cfg_ok ? cfg_target : tgt;
      err_n = !cfg_ok;
    end else if (start && (state == ARMED || state == DONE)) begin
      state_n = RUN;
      hist_n = '0;
      fill_n = '0;
      cnt_n = '0;
    end else if (state == RUN && a_valid) begin
      hist_n = h_new;
      fill_n = f_new;
      det_n = hit;
      cnt_n = hit ? cnt_inc : match_count;
      state_n = hit && cnt_inc == tgt ? DONE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      hist <= '0;
      fill <= '0;
      match_count <= '0;
      pat <= '0;
      len <= '0;
      tgt <= '0;
      detected <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      hist <= hist_n;
      fill <= fill_n;
      match_count <= cnt_n;
      pat <= pat_n;
      len <= len_n;
      tgt <= tgt_n;
      detected <= det_n;
      cfg_err <= err_n;
    end
  end
endmodule

// File: tb/tb_seq_detect_controller.sv
// tb_seq_detect_controller: directed vectors with literal checks plus a
// per-cycle comparison against a bit-queue model of the detector.
module tb_seq_detect_controller;
  logic clk = 1'b0, rst = 1'b0;
  logic cfg_valid = 0, start = 0, abort = 0, a = 0, a_valid = 0;
  logic [7:0] cfg_pattern = 0, cfg_target = 0;
  logic [3:0] cfg_len = 0;
  logic cfg_ready, cfg_err, busy, detected, done;
  logic [7:0] match_count;
  int errors = 0, checks = 0;
  bit go = 0;

  seq_detect_controller #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .cfg_err(cfg_err), .start(start), .abort(abort), .a(a), .a_valid(a_valid),
    .busy(busy), .detected(detected), .match_count(match_count), .done(done)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
  int ph = M_IDLE, m_len = 0, m_tgt = 0, m_cnt = 0;
  logic [7:0] m_pat = 0;
  bit m_det = 0, m_err = 0;
  bit bits[$];

  function automatic bit tail_match();
    int n = bits.size();
    if (n < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (bits[n - m_len + i] != m_pat[m_len - 1 - i]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    m_det = 0;
    m_err = 0;
    if (!rst) begin
      ph = M_IDLE; m_pat = 0; m_len = 0; m_tgt = 0; m_cnt = 0; bits.delete();
    end else if (abort) begin
      ph = M_IDLE; m_cnt = 0; bits.delete();
    end else if ((ph == M_IDLE || ph == M_DONE) && cfg_valid) begin
      if (cfg_len >= 2 && cfg_len <= 8 && cfg_target != 0) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_tgt = int'(cfg_target); ph = M_ARMED;
      end else m_err = 1;
    end else if (start && (ph == M_ARMED || ph == M_DONE)) begin
      ph = M_RUN; m_cnt = 0; bits.delete();
    end else if (ph == M_RUN && a_valid) begin
      bits.push_back(a);
      if (tail_match()) begin
        m_det = 1;
        m_cnt++;
        if (m_cnt == m_tgt) ph = M_DONE;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (go) begin
    chk("m_ready", cfg_ready, int'(ph == M_IDLE || ph == M_DONE));
    chk("m_busy", busy, int'(ph == M_RUN));
    chk("m_done", done, int'(ph == M_DONE));
    chk("m_detected", detected, m_det);
    chk("m_count", match_count, m_cnt);
    chk("m_cfg_err", cfg_err, m_err);
  end

  task automatic drive(input bit cv, input bit st, input bit ab, input bit av, input bit b);
    cfg_valid = cv; start = st; abort = ab; a_valid = av; a = b;
    @(negedge clk);
    cfg_valid = 0; start = 0; abort = 0; a_valid = 0; a = 0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_pattern = p; cfg_len = l; cfg_target = t;
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic bits_in(input logic [15:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      drive(0, 0, 0, 1, v[i]);
      if (gaps) begin
        drive(0, 0, 0, 0, ~v[i]);
        chk("gap_no_det", detected, 0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    go = 1;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_det", detected, 0);
    chk("rst_count", match_count, 0);
    chk("rst_done", done, 0);
    // invalid configs: length 1, length 9, target 0
    cfg(8'h33, 4'd1, 8'd2);  chk("err_len1", cfg_err, 1);
    drive(0, 0, 0, 0, 0);    chk("err_pulse", cfg_err, 0);
    cfg(8'h33, 4'd9, 8'd2);  chk("err_len9", cfg_err, 1);
    cfg(8'h33, 4'd6, 8'd0);  chk("err_tgt0", cfg_err, 1);
    drive(0, 1, 0, 0, 0);
    chk("idle_start_ign", busy, 0);
    chk("idle_ready", cfg_ready, 1);
    // 110011 with overlap, target 2
    cfg(8'h33, 4'd6, 8'd2);  chk("armed_ready", cfg_ready, 0);
    drive(0, 1, 0, 0, 0);    chk("run_busy", busy, 1);
    bits_in(16'b110011, 6, 0);
    chk("t1_det6", detected, 1);
    chk("t1_cnt1", match_count, 1);
    bits_in(16'b0, 1, 0);    chk("t1_det7", detected, 0);
    bits_in(16'b011, 3, 0);
    chk("t1_det10", detected, 1);
    chk("t1_cnt2", match_count, 2);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    // 1010 with gaps, target 3 (configured from DONE)
    cfg(8'h0A, 4'd4, 8'd3);  chk("t2_armed", cfg_ready, 0);
    drive(0, 1, 0, 0, 0);
    bits_in(16'b1010, 4, 1); chk("t2_cnt1", match_count, 1);
    bits_in(16'b1010, 4, 1);
    chk("t2_cnt3", match_count, 3);
    chk("t2_done", done, 1);
    // abort after one match; abort arrives with a completing bit
    cfg(8'h0A, 4'd4, 8'd3);
    drive(0, 1, 0, 0, 0);
    bits_in(16'b1010, 4, 0); chk("t3_cnt1", match_count, 1);
    bits_in(16'b1, 1, 0);
    drive(0, 0, 1, 1, 0);
    chk("t3_abort_det", detected, 0);
    chk("t3_abort_cnt", match_count, 0);
    chk("t3_abort_idle", cfg_ready, 1);
    chk("t3_abort_busy", busy, 0);
    // DONE with cfg_valid and start together -> ARMED
    cfg(8'h03, 4'd2, 8'd1);
    drive(0, 1, 0, 0, 0);
    bits_in(16'b11, 2, 0);   chk("t4_done", done, 1);
    cfg_pattern = 8'h05; cfg_len = 4'd3; cfg_target = 8'd1;
    drive(1, 1, 0, 0, 0);
    chk("t4_not_run", busy, 0);
    chk("t4_armed", cfg_ready, 0);
    drive(0, 1, 0, 0, 0);
    bits_in(16'b101, 3, 0);  chk("t4_det", detected, 1);
    drive(0, 1, 0, 0, 0);    chk("t4_rerun", busy, 1);
    bits_in(16'b1, 1, 0);
    // reset mid-run
    rst = 0;
    drive(0, 0, 0, 1, 0);
    rst = 1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", cfg_ready, 1);
    chk("t5_count", match_count, 0);
    chk("t5_done", done, 0);
    drive(0, 1, 0, 0, 0);    chk("t5_start_ign", busy, 0);
    // pseudo-random stream checked by the model alone
    cfg(8'h05, 4'd3, 8'd5);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 200; i++) drive(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    go = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_detect_controller.md
Name: seq_detect_controller

Overview:
- Programmable serial-pattern detection controller: accepts a pattern configuration (bits, length, match target) over a valid/ready handshake.
- Arms and runs detection on a qualified serial bit stream, counting overlapping matches until the target is reached.
- Sits between a control/config master and a serial bit source. Generalises the fixed-pattern detector FSMs into one sequenced, reconfigurable unit.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- CNT_W, 8, width of the match target and the match counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- cfg_valid  input  1  config request.
- cfg_ready  output  1  controller can accept config (high in IDLE and DONE).
- cfg_pattern  input  MAX_LEN  pattern bits; cfg_pattern[cfg_len-1] is the first-received bit; bits above cfg_len-1 are ignored.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
- cfg_target  input  CNT_W  number of matches that completes a run.
- cfg_err  output  1  one-cycle pulse: config rejected.
- start  input  1  begin a run.
- abort  input  1  cancel and return to IDLE.
- a  input  1  serial data bit.
- a_valid  input  1  qualifies a; a is ignored when low.
- busy  output  1  high in RUN.
- detected  output  1  one-cycle pulse per match.
- match_count  output  CNT_W  matches in the current run.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, history=0, fill=0, match_count=0, detected=0, cfg_err=0, done=0, busy=0, stored config=0.
- States: IDLE, ARMED, RUN, DONE. All outputs are registered or decoded from state only (Moore); no combinational path from a to detected.
- Priority within a cycle: abort > cfg handshake > start > a_valid.
- IDLE (cfg_ready=1):
  - On cfg_valid, check the config. It is valid when 2 <= cfg_len <= MAX_LEN and cfg_target != 0.
  - Valid: latch pattern, length and target; next state ARMED.
  - Invalid: cfg_err=1 for one cycle; stay IDLE; stored config unchanged.
  - start is ignored.
- ARMED (cfg_ready=0):
  - start -> RUN; clear history, fill and match_count on the same edge.
  - abort -> IDLE.
- RUN (busy=1):
  - Each a_valid cycle shifts a into history LSB.
  - fill increments and saturates at the latched length.
  - A match is history[len-1:0] == pattern[len-1:0] with fill == len, evaluated on the updated history.
  - On a match: detected pulses and match_count increments, both on the clock edge after the a_valid cycle carrying the final bit (latency 1).
  - Overlapping matches count. History is not cleared after a match.
  - Cycles with a_valid=0 hold all state.
  - When the incremented match_count equals the target, next state is DONE, entered on the same edge as the final detected pulse.
  - start is ignored. abort -> IDLE, clearing match_count and history; detected is not asserted on the abort edge.
- DONE (done=1, cfg_ready=1):
  - match_count holds.
  - start re-runs with the same config: -> RUN, clearing counters.
  - Valid cfg_valid -> ARMED with the new config. cfg_valid wins over a simultaneous start.
  - Invalid cfg_valid: cfg_err pulse; stay DONE.
  - a_valid is ignored.
- Reset mid-run behaves as power-up reset; the stored config is lost.

Test Plan:
- Reset with rst=0 for 2 cycles -> state IDLE, cfg_ready=1, detected=0, match_count=0, done=0.
- Config pattern=8'h33, len=6, target=2; start; stream 1,1,0,0,1,1,0,0,1,1 (a_valid=1) -> detected pulses the cycle after bits 6 and 10 (overlap); match_count=2; done=1 on the second pulse; busy=0.
- Config pattern=8'h0A, len=4, target=3; stream 1,0,1,0,1,0,1,0 with a_valid=0 gaps inserted -> matches after bits 4, 6 and 8; gaps neither shift nor create matches; done after the third.
- Invalid configs (len=1; len=9 with MAX_LEN=8; target=0) -> cfg_err pulses 1 cycle each; state stays IDLE; the next start is ignored.
- Abort in RUN after 1 match (target 3) -> IDLE next cycle, match_count=0, no detected pulse. Same cycle as abort, a completes a match -> abort wins.
- DONE with cfg_valid and start in the same cycle -> new config latched, state ARMED, not RUN. rst=0 mid-RUN -> IDLE, all outputs 0.
